// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control FSM:
// state encoding, supported opcodes, ALU/mux select codes and the
// packed control-strobe bundle driven to the datapath.
package mc_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11
  } state_e;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;

  localparam logic [2:0] AOP_ADD   = 3'b000;
  localparam logic [2:0] AOP_SUB   = 3'b001;
  localparam logic [2:0] AOP_RTYPE = 3'b010;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       memto_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] aop;
    logic [1:0] pc_source;
  } ctrl_t;

  // True for the opcodes this controller knows how to sequence.
  function automatic logic op_supported(input logic [OP_W-1:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_out_dec.sv
// Control-strobe decode for the multi-cycle controller.
// Ports: state_i (current state), mem_rdy_i (memory handshake),
//        rst_n_i (forces all strobes low), ctrl_o (strobe bundle).
// Everything is a function of state_i except IRWrite/PCWrite in FETCH.
module mc_out_dec
  import mc_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_rdy_i,
  input  logic   rst_n_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    if (rst_n_i) begin
      case (state_i)
        S_FETCH: begin
          ctrl_o.mem_read  = 1'b1;
          ctrl_o.alu_src_b = SRCB_FOUR;
          ctrl_o.aop       = AOP_ADD;
          ctrl_o.pc_source = PCSRC_ALU;
          // Latch IR and PC+4 only on the cycle memory delivers the word.
          ctrl_o.ir_write  = mem_rdy_i;
          ctrl_o.pc_write  = mem_rdy_i;
        end
        S_DECODE: begin
          // Speculative branch target computation.
          ctrl_o.alu_src_b = SRCB_IMM_SH;
          ctrl_o.aop       = AOP_ADD;
        end
        S_MEM_ADDR: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = SRCB_IMM;
          ctrl_o.aop       = AOP_ADD;
        end
        S_MEM_RD: begin
          ctrl_o.mem_read = 1'b1;
          ctrl_o.ior_d    = 1'b1;
        end
        S_MEM_WB: begin
          ctrl_o.memto_reg = 1'b1;
          ctrl_o.reg_write = 1'b1;
        end
        S_MEM_WR: begin
          ctrl_o.mem_write = 1'b1;
          ctrl_o.ior_d     = 1'b1;
        end
        S_R_EXEC: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = SRCB_B;
          ctrl_o.aop       = AOP_RTYPE;
        end
        S_R_WB: begin
          ctrl_o.reg_dst   = 1'b1;
          ctrl_o.reg_write = 1'b1;
        end
        S_BRANCH: begin
          ctrl_o.alu_src_a     = 1'b1;
          ctrl_o.alu_src_b     = SRCB_B;
          ctrl_o.aop           = AOP_SUB;
          ctrl_o.pc_write_cond = 1'b1;
          ctrl_o.pc_source     = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          ctrl_o.pc_write  = 1'b1;
          ctrl_o.pc_source = PCSRC_JUMP;
        end
        S_I_EXEC: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = SRCB_IMM;
          ctrl_o.aop       = AOP_ADD;
        end
        S_I_WB: begin
          ctrl_o.reg_write = 1'b1;
        end
        default: ctrl_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM with retired-instruction counter.
// Inputs : CLK, RST_N (sync active-low), OPCODE (IR[31:26]), MEM_RDY.
// Outputs: datapath strobes/selects, ILLEGAL pulse, STATE (debug),
//          INSTR_CNT (retired instructions, wraps mod 2^CNT_W).
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [5:0]       OPCODE,
  input  logic             MEM_RDY,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       AOp,
  output logic [1:0]       PCSource,
  output logic             ILLEGAL,
  output logic [3:0]       STATE,
  output logic [CNT_W-1:0] INSTR_CNT
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire_c;
  logic             illegal_c;
  ctrl_t            ctrl;

  // Next-state, retire and illegal-opcode detection.
  always_comb begin
    state_d   = state_q;
    retire_c  = 1'b0;
    illegal_c = 1'b0;
    case (state_q)
      S_FETCH:  if (MEM_RDY) state_d = S_DECODE;
      S_DECODE: begin
        case (OPCODE)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_I_EXEC;
          default: begin
            state_d   = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (OPCODE == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (MEM_RDY) state_d = S_MEM_WB;
      S_MEM_WR: begin
        if (MEM_RDY) begin
          state_d  = S_FETCH;
          retire_c = 1'b1;
        end
      end
      S_R_EXEC: state_d = S_R_WB;
      S_I_EXEC: state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: begin
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    cnt_d = retire_c ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // State and counter registers, synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  mc_out_dec u_out_dec (
    .state_i   (state_q),
    .mem_rdy_i (MEM_RDY),
    .rst_n_i   (RST_N),
    .ctrl_o    (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.ior_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.memto_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign AOp         = ctrl.aop;
  assign PCSource    = ctrl.pc_source;
  assign ILLEGAL     = illegal_c & RST_N;
  assign STATE       = RST_N ? 4'(state_q) : 4'd0;
  assign INSTR_CNT   = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected state traces are
// built from opcode and memory wait counts, then replayed cycle by cycle.
module tb_multicycle_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam int CNT_MOD = 16;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_J    = 6'b000010;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic [5:0]       OPCODE = 6'd0;
  logic             MEM_RDY = 1'b1;
  logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic             MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]       ALUSrcB, PCSource;
  logic [2:0]       AOp;
  logic             ILLEGAL;
  logic [3:0]       STATE;
  logic [CNT_W-1:0] INSTR_CNT;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [5:0] legal_ops [6];

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .OPCODE(OPCODE), .MEM_RDY(MEM_RDY),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .AOp(AOp), .PCSource(PCSource),
    .ILLEGAL(ILLEGAL), .STATE(STATE), .INSTR_CNT(INSTR_CNT)
  );

  always #5 CLK = ~CLK;

  logic [16:0] obs;
  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, AOp, PCSource};

  function automatic bit is_legal(input logic [5:0] op);
    for (int i = 0; i < 6; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Expected strobe vector for a state, straight from the state table.
  function automatic logic [16:0] exp_outs(input int st, input bit rdy);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca;
    logic [1:0] srcb, pcs;
    logic [2:0] aop;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca} = '0;
    srcb = 2'b00; pcs = 2'b00; aop = 3'b000;
    case (st)
      0:  begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      1:  srcb = 2'b11;
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin m2r = 1; rwr = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin srca = 1; aop = 3'b010; end
      7:  begin rdst = 1; rwr = 1; end
      8:  begin srca = 1; aop = 3'b001; pcwc = 1; pcs = 2'b01; end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin srca = 1; srcb = 2'b10; end
      11: rwr = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca, srcb, aop, pcs};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // One clock cycle with reset released; check all outputs against state st.
  task automatic cyc(input bit rdy, input logic [5:0] op, input int st);
    @(negedge CLK);
    RST_N = 1'b1; MEM_RDY = rdy; OPCODE = op;
    #1;
    chk("state", 32'(STATE), 32'(st));
    chk("instr_cnt", 32'(INSTR_CNT), 32'(exp_cnt));
    chk("ctrl", 32'(obs), 32'(exp_outs(st, rdy)));
    chk("illegal", 32'(ILLEGAL), 32'((st == 1) && !is_legal(op)));
  endtask

  // Build the expected state trace for one instruction and replay it.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
    int qs[$];
    bit qr[$];
    for (int i = 0; i < wf; i++) begin qs.push_back(0); qr.push_back(1'b0); end
    qs.push_back(0); qr.push_back(1'b1);
    qs.push_back(1); qr.push_back(1'($urandom));
    if (op == T_LW || op == T_SW) begin
      qs.push_back(2); qr.push_back(1'($urandom));
      for (int i = 0; i < wm; i++) begin
        qs.push_back(op == T_LW ? 3 : 5); qr.push_back(1'b0);
      end
      qs.push_back(op == T_LW ? 3 : 5); qr.push_back(1'b1);
      if (op == T_LW) begin qs.push_back(4); qr.push_back(1'($urandom)); end
    end else if (op == T_R) begin
      qs.push_back(6); qr.push_back(1'($urandom));
      qs.push_back(7); qr.push_back(1'($urandom));
    end else if (op == T_BEQ) begin
      qs.push_back(8); qr.push_back(1'($urandom));
    end else if (op == T_J) begin
      qs.push_back(9); qr.push_back(1'($urandom));
    end else if (op == T_ADDI) begin
      qs.push_back(10); qr.push_back(1'($urandom));
      qs.push_back(11); qr.push_back(1'($urandom));
    end
    for (int i = 0; i < qs.size(); i++)
      cyc(qr[i], (qs[i] == 0) ? 6'($urandom) : op, qs[i]);
    if (is_legal(op)) exp_cnt = (exp_cnt + 1) % CNT_MOD;
  endtask

  function automatic logic [5:0] rand_op(input bit allow_illegal);
    logic [5:0] op;
    if (allow_illegal && ($urandom_range(0, 7) == 0)) begin
      do op = 6'($urandom); while (is_legal(op));
      return op;
    end
    return legal_ops[$urandom_range(0, 5)];
  endfunction

  initial begin
    legal_ops = '{T_R, T_LW, T_SW, T_BEQ, T_ADDI, T_J};

    // Reset held for two edges with MEM_RDY high.
    RST_N = 1'b0; MEM_RDY = 1'b1; OPCODE = T_LW;
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1;
    chk("rst_state", 32'(STATE), 32'd0);
    chk("rst_cnt", 32'(INSTR_CNT), 32'd0);
    chk("rst_ctrl", 32'(obs), 32'd0);
    chk("rst_illegal", 32'(ILLEGAL), 32'd0);

    // Directed: lw, sw with 3 waits in MEM_WR, beq, j, illegal.
    run_instr(T_LW, 0, 0);
    run_instr(T_SW, 0, 3);
    run_instr(T_BEQ, 0, 0);
    run_instr(T_J, 0, 0);
    run_instr(6'b111111, 0, 0);
    chk("cnt_after_directed", 32'(INSTR_CNT), 32'd4);

    // Walk the counter to 15, then one addi wraps it to zero.
    while (exp_cnt != 15)
      run_instr(rand_op(1'b0), $urandom_range(0, 2), $urandom_range(0, 2));
    run_instr(T_ADDI, 0, 0);
    @(negedge CLK); RST_N = 1'b1; MEM_RDY = 1'b0; #1;
    chk("cnt_wrap", 32'(INSTR_CNT), 32'd0);

    // Random instruction mix with random memory waits.
    for (int n = 0; n < 150; n++)
      run_instr(rand_op(1'b1), $urandom_range(0, 3), $urandom_range(0, 3));

    // Reset during a MEM_RD wait aborts the lw without retiring.
    cyc(1'b1, T_LW, 0);
    cyc(1'($urandom), T_LW, 1);
    cyc(1'($urandom), T_LW, 2);
    cyc(1'b0, T_LW, 3);
    cyc(1'b0, T_LW, 3);
    @(negedge CLK); RST_N = 1'b0; MEM_RDY = 1'b1; #1;
    chk("midrst_state", 32'(STATE), 32'd0);
    chk("midrst_ctrl", 32'(obs), 32'd0);
    chk("midrst_illegal", 32'(ILLEGAL), 32'd0);
    exp_cnt = 0;
    cyc(1'b1, T_ADDI, 0);
    cyc(1'b1, T_ADDI, 1);
    cyc(1'b1, T_ADDI, 10);
    cyc(1'b1, T_ADDI, 11);
    exp_cnt = 1;
    cyc(1'b0, T_ADDI, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
